// File: rtl/alu_reg_sequencer.sv
// Command sequencer for the register-mapped TinyALU: takes one (a, b, op) request,
// runs the SRC/CMD/poll/RESULT bus sequence and returns the result or a timeout error.
module alu_reg_sequencer #(
    parameter int unsigned                ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]      SRC_ADDR    = ADDR_WIDTH'(32'h0),
    parameter logic [ADDR_WIDTH-1:0]      CMD_ADDR    = ADDR_WIDTH'(32'h4),
    parameter logic [ADDR_WIDTH-1:0]      RESULT_ADDR = ADDR_WIDTH'(32'h8),
    parameter int unsigned                TIMEOUT     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [7:0]            req_a,
    input  logic [7:0]            req_b,
    input  logic [2:0]            req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [15:0]           rsp_result,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  valid,
    output logic                  read,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [31:0]           wdata,
    output logic [3:0]            wmask,
    input  logic [31:0]           rdata
);

    localparam int unsigned CNT_W = 10;

    typedef enum logic [2:0] {
        IDLE, WR_SRC, WR_START, WR_CLR, POLL, RD_RES, RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] poll_cnt;
    logic             poll_last;
    logic             done_bit;
    logic             unused_rdata;

    assign done_bit     = rdata[1];
    assign poll_last    = (poll_cnt == CNT_W'(TIMEOUT - 1));
    assign unused_rdata = ^rdata[31:16];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req_valid) state_nxt = (req_op == 3'b000) ? RESP : WR_SRC;
            WR_SRC:   state_nxt = WR_START;
            WR_START: state_nxt = WR_CLR;
            WR_CLR:   state_nxt = POLL;
            // done on the last allowed poll still wins over the timeout
            POLL: begin
                if (done_bit)       state_nxt = RD_RES;
                else if (poll_last) state_nxt = RESP;
            end
            RD_RES:   state_nxt = RESP;
            RESP:     if (rsp_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Request latch, poll counter and response capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q        <= 8'h0;
            b_q        <= 8'h0;
            op_q       <= 3'b000;
            poll_cnt   <= '0;
            rsp_result <= 16'h0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q        <= req_a;
                        b_q        <= req_b;
                        op_q       <= req_op;
                        poll_cnt   <= '0;
                        rsp_result <= 16'h0;
                        rsp_err    <= 1'b0;
                    end
                end
                POLL: begin
                    poll_cnt <= poll_cnt + CNT_W'(1);
                    if (!done_bit && poll_last) begin
                        rsp_result <= 16'h0;
                        rsp_err    <= 1'b1;
                    end
                end
                RD_RES: begin
                    rsp_result <= rdata[15:0];
                    rsp_err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and latched request only
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        valid     = 1'b0;
        read      = 1'b0;
        addr      = '0;
        wdata     = 32'h0;
        wmask     = 4'b0000;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            WR_SRC: begin
                valid = 1'b1;
                addr  = SRC_ADDR;
                wdata = {16'h0, b_q, a_q};
                wmask = 4'b0011;
            end
            WR_START: begin
                valid = 1'b1;
                addr  = CMD_ADDR;
                wdata = {25'h0, 2'b00, op_q, 1'b0, 1'b1};
                wmask = 4'b1111;
            end
            WR_CLR: begin
                valid = 1'b1;
                addr  = CMD_ADDR;
                wdata = {25'h0, 2'b00, op_q, 1'b0, 1'b0};
                wmask = 4'b1111;
            end
            POLL: begin
                valid = 1'b1;
                read  = 1'b1;
                addr  = CMD_ADDR;
            end
            RD_RES: begin
                valid = 1'b1;
                read  = 1'b1;
                addr  = RESULT_ADDR;
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Bench for alu_reg_sequencer: a behavioural TinyALU register model on the bus, a
// vector table, randomized requests, and hand sequences for backpressure and reset.
module tb_alu_reg_sequencer;

    localparam int unsigned TMO   = 6;
    localparam logic [31:0] SRC_A = 32'h0;
    localparam logic [31:0] CMD_A = 32'h4;
    localparam logic [31:0] RES_A = 32'h8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
    logic [7:0]  req_a, req_b;
    logic [2:0]  req_op;
    logic [15:0] rsp_result;
    logic        valid, read;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wmask;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_reg_sequencer #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
        .valid(valid), .read(read), .addr(addr),
        .wdata(wdata), .wmask(wmask), .rdata(rdata)
    );

    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [4:0] op);
        if (op[2]) return 16'(a) * 16'(b);
        case (op[1:0])
            2'd1:    return 16'(a) + 16'(b);
            2'd2:    return {8'h0, a & b};
            2'd3:    return {8'h0, a ^ b};
            default: return 16'h0;
        endcase
    endfunction

    // ALU register model: done is a single-cycle pulse on poll number done_at (0 = never)
    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wmask; } wr_t;
    wr_t        wr_log[$];
    int         n_xfer = 0, n_poll = 0, n_res = 0;
    int         polls_seen = 0;
    int         done_at = 0;
    logic [7:0] src_a_q = 8'h0, src_b_q = 8'h0;
    logic [4:0] cmd_op_q = 5'h0;

    always @(posedge clk) begin
        if (valid) begin
            n_xfer <= n_xfer + 1;
            if (!read) begin
                wr_log.push_back('{addr, wdata, wmask});
                if (addr == SRC_A) begin
                    if (wmask[0]) src_a_q <= wdata[7:0];
                    if (wmask[1]) src_b_q <= wdata[15:8];
                end else if (addr == CMD_A && wdata[0]) begin
                    cmd_op_q   <= wdata[6:2];
                    polls_seen <= 0;
                end
            end else if (addr == CMD_A) begin
                n_poll     <= n_poll + 1;
                polls_seen <= polls_seen + 1;
            end else if (addr == RES_A) begin
                n_res <= n_res + 1;
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (valid && read && addr == CMD_A)
            rdata = {16'hBEEF, 14'h0, (done_at != 0 && polls_seen + 1 == done_at), 1'b0};
        else if (valid && read && addr == RES_A)
            rdata = {16'hA5A5, alu_fn(src_a_q, src_b_q, cmd_op_q)};
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    // Reference: latency/polls/result from the protocol rules
    function automatic logic done_ok(input logic [2:0] op, input int d);
        return op != 3'b000 && d >= 1 && d <= int'(TMO);
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          input int d_at, input int hold, input logic [15:0] exp_res,
                          input logic exp_err, input int exp_lat, input int exp_polls);
        int          lat, n, x0, p0, r0, w0, exp_x;
        logic [15:0] res_held;
        x0 = n_xfer; p0 = n_poll; r0 = n_res; w0 = wr_log.size();
        done_at = d_at;
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        rsp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 2000);
        check("rsp_latency", 32'(lat), 32'(exp_lat));
        check("rsp_result", 32'(rsp_result), 32'(exp_res));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        res_held = rsp_result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("held_rsp_valid", 32'(rsp_valid), 32'd1);
            check("held_result", 32'(rsp_result), 32'(res_held));
            check("held_busy_ready_bus", {29'h0, busy, req_ready, valid}, 32'b100);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_after_rsp", {29'h0, req_ready, rsp_valid, busy}, 32'b100);
        exp_x = (op == 3'b000) ? 0 : 3 + exp_polls + (exp_err ? 0 : 1);
        check("bus_transfers", 32'(n_xfer - x0), 32'(exp_x));
        check("poll_reads", 32'(n_poll - p0), 32'(op == 3'b000 ? 0 : exp_polls));
        check("result_reads", 32'(n_res - r0), 32'(op != 3'b000 && !exp_err));
        if (op != 3'b000 && wr_log.size() >= w0 + 3) begin
            check("src_addr", wr_log[w0].addr, SRC_A);
            check("src_wdata", wr_log[w0].wdata, 32'(b) * 256 + 32'(a));
            check("src_wmask", 32'(wr_log[w0].wmask), 32'h3);
            check("start_addr", wr_log[w0+1].addr, CMD_A);
            check("start_wdata", wr_log[w0+1].wdata, 32'(op) * 4 + 1);
            check("start_wmask", 32'(wr_log[w0+1].wmask), 32'hF);
            check("clr_addr", wr_log[w0+2].addr, CMD_A);
            check("clr_wdata", wr_log[w0+2].wdata, 32'(op) * 4);
        end
    endtask

    typedef struct {
        logic [7:0] a; logic [7:0] b; logic [2:0] op; int d_at;
        logic [15:0] res; logic err; int lat; int polls;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'h0F, 8'h01, 3'd1, 2, 16'h0010, 1'b0,  7, 2};
        vecs[1] = '{8'hFF, 8'hFF, 3'd4, 5, 16'hFE01, 1'b0, 10, 5};
        vecs[2] = '{8'h12, 8'h34, 3'd1, 0, 16'h0000, 1'b1, 10, 6};
        vecs[3] = '{8'h77, 8'h88, 3'd0, 3, 16'h0000, 1'b0,  1, 0};
        vecs[4] = '{8'hA5, 8'h3C, 3'd2, 1, 16'h0024, 1'b0,  6, 1};
        vecs[5] = '{8'hA5, 8'h3C, 3'd3, 6, 16'h0099, 1'b0, 11, 6};
        vecs[6] = '{8'h07, 8'h03, 3'd7, 3, 16'h0015, 1'b0,  8, 3};
        vecs[7] = '{8'h55, 8'h01, 3'd1, 7, 16'h0000, 1'b1, 10, 6};

        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = 8'h0; req_b = 8'h0; req_op = 3'b000;
        repeat (2) @(negedge clk);
        check("reset_handshake", {28'h0, req_ready, rsp_valid, rsp_err, busy}, 32'b1000);
        check("reset_result", 32'(rsp_result), 32'h0);
        check("reset_bus_ctl", {28'h0, valid, read, 2'b00}, 32'h0);
        check("reset_addr", addr, 32'h0);
        check("reset_wdata", wdata, 32'h0);
        check("reset_wmask", 32'(wmask), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].d_at, 0,
                   vecs[i].res, vecs[i].err, vecs[i].lat, vecs[i].polls);

        // No-op response held under backpressure
        run_op(8'h11, 8'h22, 3'd0, 0, 10, 16'h0, 1'b0, 1, 0);
        // Multiply with a short backpressure stall
        run_op(8'h10, 8'h10, 3'd5, 4, 3, 16'h0100, 1'b0, 9, 4);

        // Reset in the middle of polling
        done_at = 0;
        req_a = 8'h01; req_b = 8'h02; req_op = 3'd1; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_polling", {29'h0, busy, valid, read}, 32'b111);
        #2 reset = 1'b1;
        #1;
        check("mid_reset_drop", {28'h0, valid, rsp_valid, busy, req_ready}, 32'b0001);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(8'h20, 8'h03, 3'd1, 1, 0, 16'h0023, 1'b0, 6, 1);

        for (int k = 0; k < 30; k++) begin
            logic [7:0]  a, b;
            logic [2:0]  op;
            int          d, lat, polls;
            logic        ok;
            logic [15:0] res;
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 3'($urandom_range(0, 7));
            d  = int'($urandom_range(0, TMO + 1));
            ok = done_ok(op, d);
            if (op == 3'b000) begin lat = 1; polls = 0; end
            else if (ok)      begin lat = 5 + d; polls = d; end
            else              begin lat = 4 + int'(TMO); polls = int'(TMO); end
            res = ok ? alu_fn(a, b, {2'b00, op}) : 16'h0;
            run_op(a, b, op, d, int'($urandom_range(0, 2)), res,
                   op != 3'b000 && !ok, lat, polls);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
